reg_wr_scoreboard: RTL and testbench

Parametrised successor to the register-address decoder: converts destination register addresses into one-hot register-file write enables and tracks in-flight writes in a busy scoreboard. It sits between instruction issue and the register file. It stalls issue on RAW/WAW hazards and produces a registered one-hot write strobe at writeback.

---
 rtl/reg_sb_pkg.sv | 18 +
 rtl/reg_wr_scoreboard_onehot_decoder.sv | 15 +
 rtl/reg_wr_scoreboard.sv | 81 ++++++++
 tb/tb_reg_wr_scoreboard.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_sb_pkg.sv
// Shared definitions for the register write scoreboard: default address width,
// register-count derivation and a reference one-hot helper.
package reg_sb_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int MAX_ADDR_W = 8;

  function automatic int num_regs(input int aw);
    return 1 << aw;
  endfunction

  // Full-width decode, for callers that slice down to their own register count.
  function automatic logic [(1<<MAX_ADDR_W)-1:0] onehot(input logic [MAX_ADDR_W-1:0] a);
    logic [(1<<MAX_ADDR_W)-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/reg_wr_scoreboard_onehot_decoder.sv
// Address to one-hot decoder; output is all-zero when en is low.
module onehot_decoder
  import reg_sb_pkg::*;
#(
  parameter  int ADDR_W   = ADDR_W_DEF,
  localparam int NUM_REGS = num_regs(ADDR_W)
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot_o
);
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    assign onehot_o[i] = en && (addr == ADDR_W'(i));
  end
endmodule

// File: rtl/reg_wr_scoreboard.sv
// Busy scoreboard between issue and the register file: stalls RAW/WAW hazards
// and produces a registered one-hot write strobe at writeback.
module reg_wr_scoreboard
  import reg_sb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int NUM_REGS       = num_regs(ADDR_W),
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_rd_used,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic [ADDR_W-1:0]   issue_rs2,
  input  logic                issue_rs1_used,
  input  logic                issue_rs2_used,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  output logic [NUM_REGS-1:0] wb_en,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     busy_count,
  output logic                err_spurious_wb
);
  logic [NUM_REGS-1:0] busy_q, busy_d, wb_en_q, wb_en_d;
  logic [NUM_REGS-1:0] set_vec, eff_busy;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                rd_zero, wb_zero, wb_act, hazard, set_en, inc, dec;

  assign rd_zero = ZERO_HARDWIRED && (issue_rd == '0);
  assign wb_zero = ZERO_HARDWIRED && (wb_rd == '0);
  assign wb_act  = wb_valid && !wb_zero;

  // The writeback decode doubles as the clear vector and the next strobe.
  onehot_decoder #(.ADDR_W(ADDR_W)) u_wb_dec (
    .addr(wb_rd), .en(wb_act), .onehot_o(wb_en_d)
  );

  onehot_decoder #(.ADDR_W(ADDR_W)) u_rd_dec (
    .addr(issue_rd), .en(set_en), .onehot_o(set_vec)
  );

  // Same-cycle writeback relieves the hazard on its register.
  assign eff_busy = busy_q & ~wb_en_d;
  assign hazard   = (issue_rs1_used && eff_busy[issue_rs1])
                 || (issue_rs2_used && eff_busy[issue_rs2])
                 || (issue_rd_used  && eff_busy[issue_rd]);
  assign issue_ready = !hazard;
  assign set_en      = issue_valid && !hazard && issue_rd_used && !rd_zero;

  always_comb begin
    busy_d = eff_busy | set_vec;
    inc    = set_en && !busy_q[issue_rd];
    // A clear that is overridden by a same-register set does not decrement.
    dec    = wb_act && busy_q[wb_rd] && !(set_en && (issue_rd == wb_rd));
    cnt_d  = cnt_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
    err_d  = wb_act && !busy_q[wb_rd];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      wb_en_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      wb_en_q <= wb_en_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy            = busy_q;
  assign wb_en           = wb_en_q;
  assign busy_count      = cnt_q;
  assign err_spurious_wb = err_q;
endmodule

// File: tb/tb_reg_wr_scoreboard.sv
// Self-checking bench for reg_wr_scoreboard: directed scenarios plus random
// traffic compared against a bit-vector model of the hazard/busy rules.
module tb_reg_wr_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready, issue_rd_used, issue_rs1_used, issue_rs2_used;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2, wb_rd;
  logic        wb_valid, err_spurious_wb;
  logic [31:0] wb_en, busy;
  logic [5:0]  busy_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_busy;
  logic [31:0] m_wb_en;
  logic        m_err;

  always #5 clk = ~clk;

  reg_wr_scoreboard #(.ADDR_W(5), .NUM_REGS(32), .ZERO_HARDWIRED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rd(issue_rd), .issue_rd_used(issue_rd_used),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_en(wb_en), .busy(busy), .busy_count(busy_count),
    .err_spurious_wb(err_spurious_wb)
  );

  function automatic logic m_ready();
    logic [31:0] eff;
    eff = m_busy;
    if (wb_valid) eff[wb_rd] = 1'b0;
    return !((issue_rs1_used && eff[issue_rs1]) || (issue_rs2_used && eff[issue_rs2]) ||
             (issue_rd_used && eff[issue_rd]));
  endfunction

  task automatic idle();
    issue_valid = 0; issue_rd = 0; issue_rd_used = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rs1_used = 0; issue_rs2_used = 0;
    wb_valid = 0; wb_rd = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic rdu, input logic [4:0] rs1, input logic rs1u);
    issue_valid = 1; issue_rd = rd; issue_rd_used = rdu;
    issue_rs1 = rs1; issue_rs1_used = rs1u; issue_rs2 = 0; issue_rs2_used = 0;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid = 1; wb_rd = rd;
  endtask

  // Advance one clock and update the model from the rules as stated.
  task automatic tick();
    logic        acc;
    logic [31:0] nb;
    acc = issue_valid && m_ready();
    nb  = m_busy;
    if (wb_valid) nb[wb_rd] = 1'b0;
    if (acc && issue_rd_used && issue_rd != 0) nb[issue_rd] = 1'b1;
    m_err   = wb_valid && wb_rd != 0 && !m_busy[wb_rd];
    m_wb_en = (wb_valid && wb_rd != 0) ? (32'd1 << wb_rd) : 32'd0;
    m_busy  = nb;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #3;
    m_busy = 0; m_wb_en = 0; m_err = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #3;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got=%h exp=%h", busy, 32'h0); end
    checks++; if (wb_en !== 32'h0) begin errors++; $display("FAIL reset_wb_en got=%h exp=%h", wb_en, 32'h0); end
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", busy_count); end
    checks++; if (err_spurious_wb !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_spurious_wb); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
    m_busy = 0; m_wb_en = 0; m_err = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_issue_wb();
    idle(); issue(5'd3, 1, 5'd0, 0);
    tick();
    checks++; if (busy !== 32'h8) begin errors++; $display("FAIL iw_busy got=%h exp=%h", busy, 32'h8); end
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL iw_count got=%0d exp=1", busy_count); end
    idle(); wb(5'd3);
    tick();
    checks++; if (wb_en !== 32'h8) begin errors++; $display("FAIL iw_wb_en got=%h exp=%h", wb_en, 32'h8); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL iw_busy_clr got=%h exp=0", busy); end
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL iw_count_clr got=%0d exp=0", busy_count); end
    idle();
    tick();
    checks++; if (wb_en !== 32'h0) begin errors++; $display("FAIL iw_wb_en_drop got=%h exp=0", wb_en); end
  endtask

  task automatic test_bypass();
    idle(); issue(5'd5, 1, 5'd0, 0);
    tick();
    idle(); issue(5'd10, 0, 5'd5, 1);
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bp_stall got=%b exp=0", issue_ready); end
    wb(5'd5);
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL bp_relief got=%b exp=1", issue_ready); end
    tick();
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL bp_busy got=%h exp=0", busy); end
    idle();
    tick();
  endtask

  task automatic test_same_cycle();
    idle(); issue(5'd7, 1, 5'd0, 0);
    tick();
    wb(5'd7);
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sc_ready got=%b exp=1", issue_ready); end
    tick();
    checks++; if (busy !== 32'h80) begin errors++; $display("FAIL sc_busy got=%h exp=%h", busy, 32'h80); end
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL sc_count got=%0d exp=1", busy_count); end
    checks++; if (wb_en !== 32'h80) begin errors++; $display("FAIL sc_wb_en got=%h exp=%h", wb_en, 32'h80); end
    idle(); wb(5'd7);
    tick();
    idle();
    tick();
  endtask

  task automatic test_zero();
    idle(); issue(5'd0, 1, 5'd0, 1); wb(5'd0);
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL z_ready got=%b exp=1", issue_ready); end
    tick();
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL z_busy got=%h exp=0", busy); end
    checks++; if (wb_en !== 32'h0) begin errors++; $display("FAIL z_wb_en got=%h exp=0", wb_en); end
    checks++; if (err_spurious_wb !== 1'b0) begin errors++; $display("FAIL z_err got=%b exp=0", err_spurious_wb); end
    idle();
    tick();
  endtask

  task automatic test_spurious();
    idle(); wb(5'd9);
    tick();
    checks++; if (err_spurious_wb !== 1'b1) begin errors++; $display("FAIL sp_err got=%b exp=1", err_spurious_wb); end
    checks++; if (wb_en !== 32'h200) begin errors++; $display("FAIL sp_wb_en got=%h exp=%h", wb_en, 32'h200); end
    idle();
    tick();
    checks++; if (err_spurious_wb !== 1'b0) begin errors++; $display("FAIL sp_err_drop got=%b exp=0", err_spurious_wb); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      issue_valid    = ($urandom_range(0, 3) != 0);
      issue_rd       = 5'($urandom_range(0, 7));
      issue_rd_used  = ($urandom_range(0, 3) != 0);
      issue_rs1      = 5'($urandom_range(0, 7));
      issue_rs2      = 5'($urandom_range(0, 7));
      issue_rs1_used = $urandom_range(0, 1) != 0;
      issue_rs2_used = $urandom_range(0, 1) != 0;
      wb_valid       = ($urandom_range(0, 2) != 0);
      wb_rd          = 5'($urandom_range(0, 8));
      #1;
      checks++; if (issue_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, issue_ready, m_ready()); end
      tick();
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy n=%0d got=%h exp=%h", n, busy, m_busy); end
      checks++; if (busy_count !== 6'($countones(m_busy))) begin errors++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, busy_count, $countones(m_busy)); end
      checks++; if (wb_en !== m_wb_en) begin errors++; $display("FAIL rnd_wb_en n=%0d got=%h exp=%h", n, wb_en, m_wb_en); end
      checks++; if (err_spurious_wb !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err_spurious_wb, m_err); end
    end
    idle();
  endtask

  task automatic test_fill_reset();
    idle();
    do_reset();
    for (int r = 1; r < 32; r++) begin
      idle(); issue(5'(r), 1, 5'd0, 0);
      tick();
    end
    checks++; if (busy !== 32'hFFFF_FFFE) begin errors++; $display("FAIL fill_busy got=%h exp=%h", busy, 32'hFFFF_FFFE); end
    checks++; if (busy_count !== 6'd31) begin errors++; $display("FAIL fill_count got=%0d exp=31", busy_count); end
    idle(); wb(5'd4);
    tick();
    checks++; if (wb_en !== 32'h10) begin errors++; $display("FAIL fill_wb_en got=%h exp=%h", wb_en, 32'h10); end
    checks++; if (busy_count !== 6'd30) begin errors++; $display("FAIL fill_count_wb got=%0d exp=30", busy_count); end
    idle(); issue(5'd0, 0, 5'd5, 1);
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL fill_stall got=%b exp=0", issue_ready); end
    rst_n = 0;
    #1;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL ar_busy got=%h exp=0", busy); end
    checks++; if (wb_en !== 32'h0) begin errors++; $display("FAIL ar_wb_en got=%h exp=0", wb_en); end
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL ar_count got=%0d exp=0", busy_count); end
    checks++; if (err_spurious_wb !== 1'b0) begin errors++; $display("FAIL ar_err got=%b exp=0", err_spurious_wb); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got=%b exp=1", issue_ready); end
    idle();
    m_busy = 0; m_wb_en = 0; m_err = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_issue_wb();
    test_bypass();
    test_same_cycle();
    test_zero();
    test_spurious();
    test_random();
    test_fill_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
